// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares a single external ALU between two requesters using round-robin
// arbitration. A granted request has its operands and control code latched
// into registers that drive the ALU; one cycle later the ALU result and flags
// are captured and returned on a shared response channel tagged with the
// requester ID. Only one operation is in flight at a time.
//
// Ports:
//   clock, reset_n            clock (rising edge), asynchronous active-low reset
//   req_valid_N / req_ready_N request handshake for requester N (0 or 1)
//   req_a_N, req_b_N          operands for requester N
//   req_control_N             ALU control code for requester N
//   alu_input_a/b, alu_control registered drive into the ALU
//   alu_result, alu_zero, alu_cout,
//   alu_err_overflow, alu_err_invalid_control   ALU outputs
//   rsp_valid / rsp_ready     response handshake
//   rsp_id                    requester that owns the response
//   rsp_result, rsp_flags     captured result and {invalid, overflow, cout, zero}
//   busy                      high whenever an operation is in flight
//   op_count                  completed response handshakes (wraps)

module alu_arbiter #(
    parameter int WORD_SIZE           = 32,
    parameter int CONTROL_SIGNAL_SIZE = 4,
    parameter int COUNT_WIDTH         = 16
) (
    input  logic                           clock,
    input  logic                           reset_n,

    input  logic                           req_valid_0,
    output logic                           req_ready_0,
    input  logic [WORD_SIZE-1:0]           req_a_0,
    input  logic [WORD_SIZE-1:0]           req_b_0,
    input  logic [CONTROL_SIGNAL_SIZE-1:0] req_control_0,

    input  logic                           req_valid_1,
    output logic                           req_ready_1,
    input  logic [WORD_SIZE-1:0]           req_a_1,
    input  logic [WORD_SIZE-1:0]           req_b_1,
    input  logic [CONTROL_SIGNAL_SIZE-1:0] req_control_1,

    output logic [WORD_SIZE-1:0]           alu_input_a,
    output logic [WORD_SIZE-1:0]           alu_input_b,
    output logic [CONTROL_SIGNAL_SIZE-1:0] alu_control,
    input  logic [WORD_SIZE-1:0]           alu_result,
    input  logic                           alu_zero,
    input  logic                           alu_cout,
    input  logic                           alu_err_overflow,
    input  logic                           alu_err_invalid_control,

    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic                           rsp_id,
    output logic [WORD_SIZE-1:0]           rsp_result,
    output logic [3:0]                     rsp_flags,

    output logic                           busy,
    output logic [COUNT_WIDTH-1:0]         op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic                           grant_valid;
    logic                           grant_id;
    logic                           last_grant;
    logic                           cur_id;
    logic                           accept;
    logic [WORD_SIZE-1:0]           op_a;
    logic [WORD_SIZE-1:0]           op_b;
    logic [CONTROL_SIGNAL_SIZE-1:0] op_control;

    // Round-robin choice: a lone requester always wins; on contention the
    // port that did not complete the previous operation wins.
    always_comb begin
        grant_valid = req_valid_0 | req_valid_1;
        if (req_valid_0 && req_valid_1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req_valid_1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Ready is only offered in IDLE, and only to the granted port; since a
    // grant implies the port is valid, offering ready is the handshake.
    always_comb begin
        busy        = (state != IDLE);
        accept      = (state == IDLE) && grant_valid;
        req_ready_0 = accept && !grant_id;
        req_ready_1 = accept && grant_id;
    end

    // Datapath: operands are captured only at the request handshake, the ALU
    // output is captured at the end of the single EXEC cycle, and the
    // arbitration history advances only when the response is consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_control <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            op_count   <= '0;
        end else begin
            if (accept) begin
                op_a       <= grant_id ? req_a_1 : req_a_0;
                op_b       <= grant_id ? req_b_1 : req_b_0;
                op_control <= grant_id ? req_control_1 : req_control_0;
                cur_id     <= grant_id;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= cur_id;
                rsp_result <= alu_result;
                rsp_flags  <= {alu_err_invalid_control, alu_err_overflow,
                               alu_cout, alu_zero};
            end
            if ((state == RESP) && rsp_ready) begin
                rsp_valid  <= 1'b0;
                last_grant <= cur_id;
                op_count   <= op_count + 1'b1;
            end
        end
    end

    assign alu_input_a = op_a;
    assign alu_input_b = op_b;
    assign alu_control = op_control;

endmodule
